// File: rtl/ps2_mouse_pkg.sv
// ps2_mouse_pkg: shared FSM state encoding and default screen geometry.
// Used by the cursor controller and by the VGA cursor renderer.
package ps2_mouse_pkg;

    localparam int DEF_SCREEN_W = 640;
    localparam int DEF_SCREEN_H = 480;
    localparam int DEF_POS_BITS = 10;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        ACK,
        UPDATE,
        RECOVER,
        FAULT
    } state_t;

endpackage

// File: rtl/ps2_cursor_clamp.sv
// ps2_cursor_clamp: one cursor axis; adds a signed increment and saturates to [0, LIMIT-1].
// Ports:
//   pos - current position (unsigned, W bits)
//   inc - signed increment, already sign-extended to W+2 bits
//   res - clamped new position (W bits)
module ps2_cursor_clamp
    import ps2_mouse_pkg::*;
#(
    parameter int LIMIT = DEF_SCREEN_W,
    parameter int W     = DEF_POS_BITS
) (
    input  logic [W-1:0] pos,
    input  logic [W+1:0] inc,
    output logic [W-1:0] res
);

    localparam logic signed [W+1:0] MAX = (W+2)'(LIMIT - 1);

    logic signed [W+1:0] sum;

    // Two guard bits keep the sum of an unsigned position and a +/-256 step from wrapping.
    assign sum = $signed({2'b00, pos}) + $signed(inc);
    assign res = sum[W+1] ? '0 : (sum > MAX) ? MAX[W-1:0] : sum[W-1:0];

endmodule

// File: rtl/ps2_mouse_cursor_ctrl.sv
// ps2_mouse_cursor_ctrl: sequences the PS/2 mouse receiver and turns its packets into a
// clamped cursor position plus button events, with bounded reset-based recovery.
// Ports:
//   clk, reset_n                   - clock, synchronous active-low reset
//   m_data_ready, m_left, m_right  - packet strobe and button levels from the receiver
//   m_dx, m_dy                     - 9-bit two's-complement motion, mouse-up positive
//   m_error_no_ack                 - receiver failed the enable-streaming handshake
//   m_read                         - one-cycle packet acknowledge to the receiver
//   mouse_reset                    - active-high reset to the receiver
//   cursor_x, cursor_y             - cursor position
//   update                         - one-cycle strobe when cursor/button outputs change
//   left_held, right_held          - registered button levels
//   left_press, left_release, right_press - edge pulses coincident with update
//   fault                          - recovery attempts exhausted (sticky)
module ps2_mouse_cursor_ctrl
    import ps2_mouse_pkg::*;
#(
    parameter int SCREEN_W     = DEF_SCREEN_W,
    parameter int SCREEN_H     = DEF_SCREEN_H,
    parameter int POS_BITS     = DEF_POS_BITS,
    parameter int RESET_CYCLES = 16,
    parameter int MAX_RETRY    = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                m_data_ready,
    input  logic                m_left,
    input  logic                m_right,
    input  logic [8:0]          m_dx,
    input  logic [8:0]          m_dy,
    input  logic                m_error_no_ack,
    output logic                m_read,
    output logic                mouse_reset,
    output logic [POS_BITS-1:0] cursor_x,
    output logic [POS_BITS-1:0] cursor_y,
    output logic                update,
    output logic                left_held,
    output logic                right_held,
    output logic                left_press,
    output logic                left_release,
    output logic                right_press,
    output logic                fault
);

    localparam int CW = $clog2(RESET_CYCLES);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t              state, next;
    logic [CW-1:0]       cnt;
    logic [RW-1:0]       retry_cnt;
    logic [8:0]          dx, dy;
    logic                lat_left, lat_right;
    logic                pulse_done;
    logic [POS_BITS+1:0] inc_x, inc_y;
    logic [POS_BITS-1:0] nx, ny;

    assign pulse_done = cnt == CW'(RESET_CYCLES - 1);
    assign inc_x = {{(POS_BITS-7){dx[8]}}, dx};
    // Screen Y grows downward while mouse-up is positive, so Y subtracts.
    assign inc_y = -{{(POS_BITS-7){dy[8]}}, dy};

    ps2_cursor_clamp #(.LIMIT(SCREEN_W), .W(POS_BITS)) u_clamp_x (
        .pos(cursor_x),
        .inc(inc_x),
        .res(nx)
    );

    ps2_cursor_clamp #(.LIMIT(SCREEN_H), .W(POS_BITS)) u_clamp_y (
        .pos(cursor_y),
        .inc(inc_y),
        .res(ny)
    );

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= INIT;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            INIT, RECOVER: next = pulse_done ? IDLE : state;
            IDLE: begin
                // A handshake error outranks a pending packet.
                if (m_error_no_ack)
                    next = (retry_cnt < RW'(MAX_RETRY)) ? RECOVER : FAULT;
                else if (m_data_ready)
                    next = ACK;
            end
            ACK:     next = UPDATE;
            UPDATE:  next = IDLE;
            FAULT:   next = FAULT;
            default: next = INIT;
        endcase
    end

    always_comb begin
        m_read      = state == ACK;
        mouse_reset = state inside {INIT, RECOVER, FAULT};
        fault       = state == FAULT;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt          <= '0;
            retry_cnt    <= '0;
            dx           <= '0;
            dy           <= '0;
            lat_left     <= 1'b0;
            lat_right    <= 1'b0;
            cursor_x     <= POS_BITS'(SCREEN_W / 2);
            cursor_y     <= POS_BITS'(SCREEN_H / 2);
            update       <= 1'b0;
            left_held    <= 1'b0;
            right_held   <= 1'b0;
            left_press   <= 1'b0;
            left_release <= 1'b0;
            right_press  <= 1'b0;
        end else begin
            cnt <= ((state == INIT || state == RECOVER) && !pulse_done) ? cnt + 1'b1 : '0;
            if (state == IDLE && next == RECOVER)
                retry_cnt <= retry_cnt + 1'b1;
            else if (state == UPDATE)
                retry_cnt <= '0;
            if (state == ACK) begin
                dx        <= m_dx;
                dy        <= m_dy;
                lat_left  <= m_left;
                lat_right <= m_right;
            end
            update       <= state == UPDATE;
            left_press   <= state == UPDATE && lat_left && !left_held;
            left_release <= state == UPDATE && !lat_left && left_held;
            right_press  <= state == UPDATE && lat_right && !right_held;
            if (state == UPDATE) begin
                cursor_x   <= nx;
                cursor_y   <= ny;
                left_held  <= lat_left;
                right_held <= lat_right;
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_cursor_ctrl.sv
// tb_ps2_mouse_cursor_ctrl: self-checking bench for the PS/2 mouse cursor controller.
module tb_ps2_mouse_cursor_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       m_data_ready = 1'b0;
    logic       m_left = 1'b0;
    logic       m_right = 1'b0;
    logic [8:0] m_dx = '0;
    logic [8:0] m_dy = '0;
    logic       m_error_no_ack = 1'b0;
    logic       m_read, mouse_reset, update, fault;
    logic       left_held, right_held, left_press, left_release, right_press;
    logic [9:0] cursor_x, cursor_y;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       lh;
        logic       rh;
        logic       lp;
        logic       lr;
        logic       rp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mx, my;
    logic mlh, mrh;

    ps2_mouse_cursor_ctrl dut (
        .clk(clk),
        .reset_n(reset_n),
        .m_data_ready(m_data_ready),
        .m_left(m_left),
        .m_right(m_right),
        .m_dx(m_dx),
        .m_dy(m_dy),
        .m_error_no_ack(m_error_no_ack),
        .m_read(m_read),
        .mouse_reset(mouse_reset),
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
        .update(update),
        .left_held(left_held),
        .right_held(right_held),
        .left_press(left_press),
        .left_release(left_release),
        .right_press(right_press),
        .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic int clampi(input int v, input int lim);
        return v < 0 ? 0 : (v > lim - 1 ? lim - 1 : v);
    endfunction

    function automatic int s9(input logic [8:0] v);
        return v[8] ? int'(v) - 512 : int'(v);
    endfunction

    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (mouse_reset === lvl && n < 200) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [8:0] dx, input logic [8:0] dy, input logic l, input logic r);
        exp_t e, got;
        mx = clampi(mx + s9(dx), 640);
        my = clampi(my - s9(dy), 480);
        e.x = 10'(mx);
        e.y = 10'(my);
        e.lh = l;
        e.rh = r;
        e.lp = l & ~mlh;
        e.lr = ~l & mlh;
        e.rp = r & ~mrh;
        mlh = l;
        mrh = r;
        q.push_back(e);
        m_dx = dx;
        m_dy = dy;
        m_left = l;
        m_right = r;
        m_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_read !== 1'b1) begin
            errors++;
            $display("FAIL ack_pulse m_read=%b want 1", m_read);
        end
        m_data_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (m_read !== 1'b0 || update !== 1'b0) begin
            errors++;
            $display("FAIL ack_timing m_read=%b update=%b want 0 0", m_read, update);
        end
        @(negedge clk);
        checks++;
        if (update !== 1'b1 || m_read !== 1'b0) begin
            errors++;
            $display("FAIL update_latency update=%b m_read=%b want 1 0", update, m_read);
        end else begin
            got = {cursor_x, cursor_y, left_held, right_held, left_press, left_release, right_press};
            e = q.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL packet_result got x=%0d y=%0d lh=%b rh=%b lp=%b lr=%b rp=%b want x=%0d y=%0d lh=%b rh=%b lp=%b lr=%b rp=%b",
                         got.x, got.y, got.lh, got.rh, got.lp, got.lr, got.rp,
                         e.x, e.y, e.lh, e.rh, e.lp, e.lr, e.rp);
            end
        end
    endtask

    task automatic model_reset();
        mx = 320;
        my = 240;
        mlh = 1'b0;
        mrh = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (mouse_reset !== 1'b1 || m_read !== 1'b0 || update !== 1'b0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl mouse_reset=%b m_read=%b update=%b fault=%b want 1 0 0 0",
                     mouse_reset, m_read, update, fault);
        end
        checks++;
        if (cursor_x !== 10'd320 || cursor_y !== 10'd240 || left_held !== 1'b0 || right_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_cursor x=%0d y=%0d lh=%b rh=%b want 320 240 0 0",
                     cursor_x, cursor_y, left_held, right_held);
        end
        reset_n = 1'b1;
        count_level(1'b1, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL init_pulse_len got %0d want 16", n);
        end
        checks++;
        if (cursor_x !== 10'd320 || cursor_y !== 10'd240 || m_read !== 1'b0) begin
            errors++;
            $display("FAIL init_idle x=%0d y=%0d m_read=%b want 320 240 0", cursor_x, cursor_y, m_read);
        end
    endtask

    task automatic test_packet();
        send(9'd5, 9'd3, 1'b0, 1'b0);
        checks++;
        if (cursor_x !== 10'd325 || cursor_y !== 10'd237) begin
            errors++;
            $display("FAIL basic_move x=%0d y=%0d want 325 237", cursor_x, cursor_y);
        end
        @(negedge clk);
        checks++;
        if (update !== 1'b0) begin
            errors++;
            $display("FAIL update_width update=%b want 0", update);
        end
    endtask

    task automatic test_clamp();
        send(9'h100, 9'h10F, 1'b0, 1'b0);
        send(9'h1BD, 9'h000, 1'b0, 1'b0);
        checks++;
        if (cursor_x !== 10'd2 || cursor_y !== 10'd478) begin
            errors++;
            $display("FAIL clamp_setup x=%0d y=%0d want 2 478", cursor_x, cursor_y);
        end
        send(9'h1F6, 9'h1F6, 1'b0, 1'b0);
        checks++;
        if (cursor_x !== 10'd0 || cursor_y !== 10'd479) begin
            errors++;
            $display("FAIL clamp_low_x_high_y x=%0d y=%0d want 0 479", cursor_x, cursor_y);
        end
        repeat (3) send(9'h0FF, 9'h000, 1'b0, 1'b0);
        checks++;
        if (cursor_x !== 10'd639) begin
            errors++;
            $display("FAIL clamp_high_x x=%0d want 639", cursor_x);
        end
        repeat (2) send(9'h000, 9'h0FF, 1'b0, 1'b0);
        checks++;
        if (cursor_y !== 10'd0) begin
            errors++;
            $display("FAIL clamp_low_y y=%0d want 0", cursor_y);
        end
    endtask

    task automatic test_buttons();
        send(9'd1, 9'd0, 1'b1, 1'b0);
        send(9'd1, 9'd0, 1'b0, 1'b0);
        send(9'd0, 9'd1, 1'b0, 1'b1);
        send(9'd0, 9'd1, 1'b0, 1'b1);
        send(9'd0, 9'd0, 1'b1, 1'b0);
        checks++;
        if (left_held !== 1'b1 || right_held !== 1'b0) begin
            errors++;
            $display("FAIL button_levels lh=%b rh=%b want 1 0", left_held, right_held);
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        t0 = cyc;
        for (int i = 0; i < 6; i++)
            send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        checks++;
        if (cyc - t0 != 18) begin
            errors++;
            $display("FAIL back_to_back_rate got %0d cycles want 18", cyc - t0);
        end
    endtask

    task automatic test_priority();
        int n;
        m_error_no_ack = 1'b1;
        m_data_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m_read !== 1'b0 || mouse_reset !== 1'b1) begin
            errors++;
            $display("FAIL error_priority m_read=%b mouse_reset=%b want 0 1", m_read, mouse_reset);
        end
        m_error_no_ack = 1'b0;
        m_data_ready = 1'b0;
        count_level(1'b1, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL recover_pulse_len got %0d want 16", n);
        end
        send(9'd3, 9'd3, 1'b0, 1'b0);
    endtask

    task automatic test_fault();
        int n;
        int bad;
        m_error_no_ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            count_level(1'b1, n);
            checks++;
            if (n != 16) begin
                errors++;
                $display("FAIL retry%0d_pulse_len got %0d want 16", i, n);
            end
            count_level(1'b0, n);
            checks++;
            if (n != 1) begin
                errors++;
                $display("FAIL retry%0d_gap got %0d want 1", i, n);
            end
        end
        checks++;
        if (fault !== 1'b1 || mouse_reset !== 1'b1) begin
            errors++;
            $display("FAIL fault_state fault=%b mouse_reset=%b want 1 1", fault, mouse_reset);
        end
        m_error_no_ack = 1'b0;
        m_data_ready = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (m_read !== 1'b0 || fault !== 1'b1 || mouse_reset !== 1'b1) bad++;
        end
        m_data_ready = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL fault_absorbing bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        count_level(1'b1, n);
        checks++;
        if (n != 16 || fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_cleared pulse=%0d fault=%b want 16 0", n, fault);
        end
        send(9'd10, 9'd0, 1'b0, 1'b0);
        m_dx = 9'd7;
        m_dy = 9'd7;
        m_left = 1'b1;
        m_data_ready = 1'b1;
        @(negedge clk);
        m_data_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (update !== 1'b0 || cursor_x !== 10'd320 || cursor_y !== 10'd240 || left_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_update update=%b x=%0d y=%0d lh=%b want 0 320 240 0",
                     update, cursor_x, cursor_y, left_held);
        end
        reset_n = 1'b1;
        count_level(1'b1, n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL reinit_pulse_len got %0d want 16", n);
        end
        send(9'd2, 9'd2, 1'b1, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_packet();
        test_clamp();
        test_buttons();
        test_back_to_back();
        test_priority();
        test_fault();
        test_reset_mid();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
